// File: rtl/wb_writeback_io_pkg.sv
// Shared definitions for the write-back stage: MemtoReg encodings,
// register-file geometry, the bubble encoding and IN/OUT port decode.
package wb_writeback_io_pkg;

    // Register file geometry
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    // An all-zero instruction word is a bubble and never retires
    localparam int NOP_INST = 0;

    // Write-back data source select
    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC  = 2'b10,
        MTR_IN  = 2'b11
    } mtr_e;

    // Port operation actually performed this cycle after priority resolution
    typedef struct packed {
        logic in_op;
        logic out_op;
    } port_op_t;

    // IN has priority; an OUT flagged together with an IN is dropped
    function automatic port_op_t decode_port(input logic wb_in, input logic wb_out);
        port_op_t op;
        op.in_op  = wb_in;
        op.out_op = wb_out & ~wb_in;
        return op;
    endfunction

endpackage

// File: rtl/wb_writeback_io_regfile_8xn.sv
// 8 x n register file: one synchronous write port and two asynchronous
// read ports. A read of the register being written this cycle returns the
// write data, so ID sees the value before it lands in the flops.
module regfile_8xn
    import wb_writeback_io_pkg::*;
#(
    parameter int n = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [n-1:0]      wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [n-1:0]      rdata_a,
    output logic [n-1:0]      rdata_b
);

    logic [n-1:0] regs_q [NUM_REGS];
    logic [n-1:0] regs_d [NUM_REGS];

    // Next-state: copy current contents, overwrite the addressed entry on a write
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage; every entry, R0 included, clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A with write-through bypass
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (we && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    // Read port B with write-through bypass
    always_comb begin
        rdata_b = regs_q[raddr_b];
        if (we && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/wb_writeback_io.sv
// Write-back stage of the 16-bit pipelined core. Picks the write-back value,
// commits it to the register file, runs the IN/OUT port handshakes and stalls
// the whole pipeline while a port transfer cannot complete.
module wb_writeback_io
    import wb_writeback_io_pkg::*;
#(
    parameter int n     = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        WB_MemtoReg,
    input  logic [n-1:0]      WB_inst,
    input  logic [n-1:0]      WB_PC_adder_out,
    input  logic [n-1:0]      WB_ReadData_dmem,
    input  logic [n-1:0]      WB_ALU_out,
    input  logic              WB_IN,
    input  logic              WB_OUT,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_WriteRegister,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [n-1:0]      rd_data_a,
    output logic [n-1:0]      rd_data_b,
    input  logic [n-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [n-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stall,
    output logic [CNT_W-1:0]  retire_cnt
);

    port_op_t         port_op;
    logic             commit;
    logic             reg_we;
    logic [n-1:0]     wdata;

    logic [n-1:0]     out_data_q;
    logic [n-1:0]     out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;

    // Port decode, stall and commit; reset forces a quiet, non-committing cycle
    always_comb begin
        port_op  = decode_port(WB_IN, WB_OUT);
        in_ready = port_op.in_op & in_valid & ~rst;
        stall    = ~rst & ((port_op.in_op & ~in_valid) |
                           (port_op.out_op & out_valid_q & ~out_ready));
        commit   = ~stall & ~rst;
        reg_we   = commit & WB_RegWrite;
    end

    // Write-back data select
    always_comb begin
        wdata = WB_ALU_out;
        case (WB_MemtoReg)
            MTR_ALU: wdata = WB_ALU_out;
            MTR_MEM: wdata = WB_ReadData_dmem;
            MTR_PC:  wdata = WB_PC_adder_out;
            MTR_IN:  wdata = in_data;
            default: wdata = WB_ALU_out;
        endcase
    end

    regfile_8xn #(
        .n(n)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (reg_we),
        .waddr   (WB_WriteRegister),
        .wdata   (wdata),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rd_data_a),
        .rdata_b (rd_data_b)
    );

    // Output holding register: a sink accept frees the slot, a committed OUT refills it
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (commit && port_op.out_op) begin
            out_data_d  = WB_ALU_out;
            out_valid_d = 1'b1;
        end
    end

    // Retired-instruction counter; bubbles do not count and the value wraps
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit && (WB_inst != n'(NOP_INST))) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // State registers for the output port and the retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign retire_cnt = retire_cnt_q;

    // An IN instruction must route the port data into the register file
    in_mtr_check: assert property (@(posedge clk) disable iff (rst)
        WB_IN |-> (WB_MemtoReg == MTR_IN));

endmodule

// File: tb/tb_wb_writeback_io.sv
// Self-checking bench for wb_writeback_io: a table of register-write vectors,
// hand-written port sequences, a reference model and an OUT scoreboard.
module tb_wb_writeback_io;
    import wb_writeback_io_pkg::*;

    typedef struct {
        logic        rst;
        logic [1:0]  mtr;
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] dmem;
        logic [15:0] alu;
        logic        win;
        logic        wout;
        logic        rw;
        logic [2:0]  wr;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] in_d;
        logic        in_v;
        logic        out_r;
        logic        exp_stall;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB_MemtoReg;
    logic [15:0] WB_inst, WB_PC_adder_out, WB_ReadData_dmem, WB_ALU_out;
    logic        WB_IN, WB_OUT, WB_RegWrite;
    logic [2:0]  WB_WriteRegister, rd_addr_a, rd_addr_b;
    logic [15:0] in_data;
    logic        in_valid, out_ready;

    logic [15:0] rd_data_a, rd_data_b, out_data;
    logic        in_ready, out_valid, stall;
    logic [15:0] retire_cnt;

    logic [15:0] rd_data_a_w, rd_data_b_w, out_data_w;
    logic        in_ready_w, out_valid_w, stall_w;
    logic [3:0]  retire_cnt_w;

    logic [15:0] m_regs [8];
    logic [15:0] m_out_data;
    logic        m_out_valid;
    logic [15:0] m_cnt;
    logic        m_commit;
    logic [15:0] sb_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_writeback_io #(.n(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .WB_MemtoReg(WB_MemtoReg), .WB_inst(WB_inst),
        .WB_PC_adder_out(WB_PC_adder_out), .WB_ReadData_dmem(WB_ReadData_dmem),
        .WB_ALU_out(WB_ALU_out), .WB_IN(WB_IN), .WB_OUT(WB_OUT),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .stall(stall), .retire_cnt(retire_cnt)
    );

    wb_writeback_io #(.n(16), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .WB_MemtoReg(WB_MemtoReg), .WB_inst(WB_inst),
        .WB_PC_adder_out(WB_PC_adder_out), .WB_ReadData_dmem(WB_ReadData_dmem),
        .WB_ALU_out(WB_ALU_out), .WB_IN(WB_IN), .WB_OUT(WB_OUT),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_w), .rd_data_b(rd_data_b_w),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .stall(stall_w), .retire_cnt(retire_cnt_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{rst: 1'b0, mtr: 2'b00, inst: 16'h0, pc: 16'h0, dmem: 16'h0, alu: 16'h0,
              win: 1'b0, wout: 1'b0, rw: 1'b0, wr: 3'd0, ra: 3'd0, rb: 3'd0,
              in_d: 16'h0, in_v: 1'b0, out_r: 1'b1, exp_stall: 1'b0,
              exp_a: 16'h0, exp_b: 16'h0};
        return v;
    endfunction

    function automatic vec_t row(input logic rw, input logic [1:0] mtr, input logic [15:0] val,
                                 input logic [2:0] wr, input logic [2:0] ra, input logic [2:0] rb,
                                 input logic [15:0] inst, input logic [15:0] ea,
                                 input logic [15:0] eb);
        vec_t v;
        v = idle();
        v.rw = rw; v.mtr = mtr; v.wr = wr; v.ra = ra; v.rb = rb; v.inst = inst;
        v.exp_a = ea; v.exp_b = eb;
        case (mtr)
            2'b00:   v.alu  = val;
            2'b01:   v.dmem = val;
            2'b10:   v.pc   = val;
            default: v.in_d = val;
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; WB_MemtoReg = v.mtr; WB_inst = v.inst;
        WB_PC_adder_out = v.pc; WB_ReadData_dmem = v.dmem; WB_ALU_out = v.alu;
        WB_IN = v.win; WB_OUT = v.wout; WB_RegWrite = v.rw;
        WB_WriteRegister = v.wr; rd_addr_a = v.ra; rd_addr_b = v.rb;
        in_data = v.in_d; in_valid = v.in_v; out_ready = v.out_r;
    endtask

    function automatic logic [15:0] modelWdata();
        case (WB_MemtoReg)
            2'b00:   return WB_ALU_out;
            2'b01:   return WB_ReadData_dmem;
            2'b10:   return WB_PC_adder_out;
            default: return in_data;
        endcase
    endfunction

    // Compare every output against the model; pop the scoreboard on an output transfer
    task automatic checkOutput();
        logic        ms, mir;
        logic [15:0] wd, ea, eb, expd;
        wd  = modelWdata();
        ms  = !rst && ((WB_IN && !in_valid) || (WB_OUT && !WB_IN && m_out_valid && !out_ready));
        mir = WB_IN && in_valid && !rst;
        m_commit = !ms && !rst;
        ea = (WB_RegWrite && m_commit && rd_addr_a == WB_WriteRegister) ? wd : m_regs[rd_addr_a];
        eb = (WB_RegWrite && m_commit && rd_addr_b == WB_WriteRegister) ? wd : m_regs[rd_addr_b];
        check("stall", stall, ms);
        check("in_ready", in_ready, mir);
        check("rd_data_a", rd_data_a, ea);
        check("rd_data_b", rd_data_b, eb);
        check("out_valid", out_valid, m_out_valid);
        check("out_data", out_data, m_out_data);
        check("retire_cnt", retire_cnt, m_cnt);
        check("retire_cnt_w4", retire_cnt_w, m_cnt[3:0]);
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out", 1, 0);
            end else begin
                expd = sb_q.pop_front();
                check("sb_out_data", out_data, expd);
            end
        end
    endtask

    task automatic endCycle();
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_out_data = 16'h0; m_out_valid = 1'b0; m_cnt = 16'h0;
            sb_q.delete();
        end else begin
            if (m_out_valid && out_ready) m_out_valid = 1'b0;
            if (m_commit) begin
                if (WB_RegWrite) m_regs[WB_WriteRegister] = modelWdata();
                if (WB_OUT && !WB_IN) begin
                    m_out_data  = WB_ALU_out;
                    m_out_valid = 1'b1;
                    sb_q.push_back(WB_ALU_out);
                end
                if (WB_inst != 16'h0) m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic finishCycle();
        checkOutput();
        endCycle();
    endtask

    task automatic cycle(input vec_t v);
        applyStimulus(v);
        settle();
        finishCycle();
    endtask

    vec_t tbl [8];

    initial begin
        vec_t v;
        logic [15:0] cnt0;

        tbl[0] = row(1'b1, 2'b00, 16'h1234, 3'd3, 3'd3, 3'd0, 16'h1001, 16'h1234, 16'h0000);
        tbl[1] = row(1'b0, 2'b00, 16'h9999, 3'd3, 3'd3, 3'd3, 16'h0000, 16'h1234, 16'h1234);
        tbl[2] = row(1'b1, 2'b01, 16'hBEEF, 3'd5, 3'd5, 3'd3, 16'h1002, 16'hBEEF, 16'h1234);
        tbl[3] = row(1'b1, 2'b10, 16'h0042, 3'd0, 3'd0, 3'd5, 16'h1003, 16'h0042, 16'hBEEF);
        tbl[4] = row(1'b1, 2'b00, 16'hFFFF, 3'd7, 3'd6, 3'd7, 16'h1004, 16'h0000, 16'hFFFF);
        tbl[5] = row(1'b0, 2'b00, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0042, 16'hFFFF);
        tbl[6] = row(1'b1, 2'b11, 16'h0C0C, 3'd2, 3'd2, 3'd1, 16'h1005, 16'h0C0C, 16'h0000);
        tbl[7] = row(1'b0, 2'b00, 16'h0000, 3'd2, 3'd2, 3'd2, 16'h0000, 16'h0C0C, 16'h0C0C);

        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_out_data = 16'h0; m_out_valid = 1'b0; m_cnt = 16'h0; m_commit = 1'b0;

        v = idle(); v.rst = 1'b1;
        applyStimulus(v);
        @(posedge clk); #1;
        cycle(v);
        settle();
        check("reset_stall", stall, 0);
        check("reset_in_ready", in_ready, 0);
        finishCycle();

        // Register writes through every MemtoReg source, with bypass
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            settle();
            check($sformatf("tbl%0d_stall", i), stall, tbl[i].exp_stall);
            check($sformatf("tbl%0d_rd_a", i), rd_data_a, tbl[i].exp_a);
            check($sformatf("tbl%0d_rd_b", i), rd_data_b, tbl[i].exp_b);
            finishCycle();
        end
        settle();
        check("tbl_retire_cnt", retire_cnt, 16'd5);
        finishCycle();

        // IN starved for three cycles, then data arrives
        cnt0 = m_cnt;
        v = idle(); v.win = 1'b1; v.mtr = 2'b11; v.rw = 1'b1; v.wr = 3'd4; v.ra = 3'd4;
        v.inst = 16'h2001; v.in_v = 1'b0; v.in_d = 16'h00AB;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(v);
            settle();
            check("in_starve_stall", stall, 1);
            check("in_starve_ready", in_ready, 0);
            check("in_starve_rd_a", rd_data_a, 16'h0000);
            finishCycle();
        end
        v.in_v = 1'b1;
        applyStimulus(v);
        settle();
        check("in_go_stall", stall, 0);
        check("in_go_ready", in_ready, 1);
        check("in_go_bypass", rd_data_a, 16'h00AB);
        finishCycle();
        v = idle(); v.ra = 3'd4;
        applyStimulus(v);
        settle();
        check("in_r4", rd_data_a, 16'h00AB);
        check("in_retire_once", retire_cnt, cnt0 + 16'd1);
        finishCycle();

        // Two back-to-back OUTs under backpressure
        v = idle(); v.wout = 1'b1; v.alu = 16'h0011; v.inst = 16'h3001; v.out_r = 1'b0;
        applyStimulus(v);
        settle();
        check("out1_stall", stall, 0);
        finishCycle();
        v.alu = 16'h0022; v.inst = 16'h3002;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(v);
            settle();
            check("out2_stall", stall, 1);
            check("out2_held_data", out_data, 16'h0011);
            check("out2_held_valid", out_valid, 1);
            finishCycle();
        end
        v.out_r = 1'b1;
        applyStimulus(v);
        settle();
        check("out2_accept_stall", stall, 0);
        finishCycle();
        v = idle(); v.out_r = 1'b0;
        applyStimulus(v);
        settle();
        check("out2_loaded_data", out_data, 16'h0022);
        check("out2_loaded_valid", out_valid, 1);
        finishCycle();
        cycle(idle());

        // Simultaneous accept and new load
        v = idle(); v.wout = 1'b1; v.alu = 16'h3333; v.inst = 16'h4001;
        cycle(v);
        v.alu = 16'h5555; v.inst = 16'h4002;
        applyStimulus(v);
        settle();
        check("simul_valid_before", out_valid, 1);
        check("simul_stall", stall, 0);
        finishCycle();
        v = idle(); v.out_r = 1'b0;
        applyStimulus(v);
        settle();
        check("simul_valid_after", out_valid, 1);
        check("simul_data_after", out_data, 16'h5555);
        finishCycle();
        cycle(idle());

        // Reset while an IN is starved and an OUT is pending
        v = idle(); v.wout = 1'b1; v.alu = 16'h7777; v.inst = 16'h5001; v.out_r = 1'b0;
        cycle(v);
        v = idle(); v.win = 1'b1; v.mtr = 2'b11; v.rw = 1'b1; v.wr = 3'd1; v.inst = 16'h5002;
        v.in_v = 1'b0; v.out_r = 1'b0;
        applyStimulus(v);
        settle();
        check("rst_pre_stall", stall, 1);
        finishCycle();
        v.rst = 1'b1; v.in_v = 1'b1; v.in_d = 16'hDEAD;
        applyStimulus(v);
        settle();
        check("rst_mid_stall", stall, 0);
        check("rst_mid_in_ready", in_ready, 0);
        finishCycle();
        for (int i = 0; i < 4; i++) begin
            v = idle(); v.ra = 3'(2 * i); v.rb = 3'(2 * i + 1);
            applyStimulus(v);
            settle();
            check("rst_post_regs_a", rd_data_a, 16'h0000);
            check("rst_post_regs_b", rd_data_b, 16'h0000);
            if (i == 0) begin
                check("rst_post_out_valid", out_valid, 0);
                check("rst_post_retire", retire_cnt, 16'h0000);
                check("rst_post_stall", stall, 0);
            end
            finishCycle();
        end

        // Counter wrap: 17 retiring instructions and 3 bubbles
        for (int i = 0; i < 20; i++) begin
            v = idle();
            v.inst = ((i % 7) == 3) ? 16'h0000 : (16'h0100 + 16'(i));
            cycle(v);
        end
        settle();
        check("wrap_cnt_w4", retire_cnt_w, 4'd1);
        check("wrap_cnt_16", retire_cnt, 16'd17);
        finishCycle();

        cycle(idle());
        settle();
        check("drain_out_valid", out_valid, 0);
        check("drain_scoreboard_empty", sb_q.size(), 0);
        finishCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
